mem_bus_dbg_initiator: RTL and testbench

Byte-stream-driven initiator for the 14-bit-address / 16-bit-data memory bus that feeds the mapped register file and data memory. It accepts command bytes from a debug link, for example a UART receiver. It then requests the bus from the core, performs single-cycle reads or writes, and streams read data back as bytes. It sits beside the core as a second bus master and gives a host peek/poke access to RAM and mapped peripherals.

---
 rtl/mem_bus_dbg_initiator_if.sv | 27 ++
 rtl/mem_bus_dbg_initiator.sv | 140 ++++++++++++++
 tb/tb_mem_bus_dbg_initiator.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_dbg_initiator_if.sv
// Debug-link byte streams and memory-bus signals of mem_bus_dbg_initiator.
// The master modport is the initiator's view of the bus.
interface mem_bus_dbg_initiator_if;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        busReq;
  logic        busGnt;
  logic [13:0] memAddr;
  logic [15:0] memDataOut;
  logic        memWrEn;
  logic [15:0] memDataIn;
  logic        busy;

  modport master (
    input  rxData, rxValid, txReady, busGnt, memDataIn,
    output rxReady, txData, txValid, busReq, memAddr, memDataOut, memWrEn, busy
  );

  modport slave (
    output rxData, rxValid, txReady, busGnt, memDataIn,
    input  rxReady, txData, txValid, busReq, memAddr, memDataOut, memWrEn, busy
  );
endinterface

// File: rtl/mem_bus_dbg_initiator.sv
// Byte-stream debug initiator: header bytes in, one bus access per count, read data out as bytes.
// Define DBG_BURST_EN to accept a LEN header byte (1-256 accesses, auto-incrementing address).
module mem_bus_dbg_initiator (
  input  logic                            i_clk,
  input  logic                            i_rst,
  mem_bus_dbg_initiator_if.master         bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, LEN, WDH, WDL, REQ, ACC, RSH, RSL, NEXT
  } state_t;

  state_t      state, stateNext;
  logic        wrCmd;
  logic [13:0] addrReg;
  logic [15:0] dataReg;
  logic [15:0] rdBuf;
  logic        lastAccess;
  logic        rxReadyC;
  logic        txValidC;
  logic [7:0]  txDataC;
  logic        busReqC;
  logic        memWrEnC;

`ifdef DBG_BURST_EN
  logic [8:0]  remaining;
  assign lastAccess = (remaining == 9'd1);
`else
  assign lastAccess = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrCmd     <= 1'b0;
      addrReg   <= '0;
      dataReg   <= '0;
      rdBuf     <= '0;
`ifdef DBG_BURST_EN
      remaining <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.rxValid) begin
          wrCmd          <= bus.rxData[7];
          addrReg[13:8]  <= bus.rxData[5:0];
        end
        ADDR: if (bus.rxValid) addrReg[7:0] <= bus.rxData;
`ifdef DBG_BURST_EN
        LEN:  if (bus.rxValid)
          remaining <= (bus.rxData == 8'd0) ? 9'd256 : {1'b0, bus.rxData};
`endif
        WDH:  if (bus.rxValid) dataReg[15:8] <= bus.rxData;
        WDL:  if (bus.rxValid) dataReg[7:0]  <= bus.rxData;
        ACC:  if (!wrCmd)      rdBuf         <= bus.memDataIn;
        NEXT: begin
          addrReg <= addrReg + 14'd1;
`ifdef DBG_BURST_EN
          remaining <= remaining - 9'd1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    rxReadyC  = 1'b0;
    txValidC  = 1'b0;
    txDataC   = '0;
    busReqC   = 1'b0;
    memWrEnC  = 1'b0;
    case (state)
      IDLE: begin
        rxReadyC = 1'b1;
        if (bus.rxValid) stateNext = ADDR;
      end
      ADDR: begin
        rxReadyC = 1'b1;
`ifdef DBG_BURST_EN
        if (bus.rxValid) stateNext = LEN;
`else
        if (bus.rxValid) stateNext = wrCmd ? WDH : REQ;
`endif
      end
      LEN: begin
        rxReadyC = 1'b1;
        if (bus.rxValid) stateNext = wrCmd ? WDH : REQ;
      end
      WDH: begin
        rxReadyC = 1'b1;
        if (bus.rxValid) stateNext = WDL;
      end
      WDL: begin
        rxReadyC = 1'b1;
        if (bus.rxValid) stateNext = REQ;
      end
      REQ: begin
        busReqC = 1'b1;
        if (bus.busGnt) stateNext = ACC;
      end
      ACC: begin
        busReqC = 1'b1;
        // Strobe is masked by reset so an aborted write never reaches the bus.
        memWrEnC  = wrCmd & ~i_rst;
        stateNext = wrCmd ? NEXT : RSH;
      end
      RSH: begin
        txValidC = 1'b1;
        txDataC  = rdBuf[15:8];
        if (bus.txReady) stateNext = RSL;
      end
      RSL: begin
        txValidC = 1'b1;
        txDataC  = rdBuf[7:0];
        if (bus.txReady) stateNext = NEXT;
      end
      NEXT: begin
        if (lastAccess) stateNext = IDLE;
        else            stateNext = wrCmd ? WDH : REQ;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.rxReady    = rxReadyC;
  assign bus.txValid    = txValidC;
  assign bus.txData     = txDataC;
  assign bus.busReq     = busReqC;
  assign bus.memWrEn    = memWrEnC;
  assign bus.memAddr    = addrReg;
  assign bus.memDataOut = dataReg;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_dbg_initiator.sv
// Directed bench for mem_bus_dbg_initiator: vector table of single commands plus
// hand-written backpressure, reset-during-access and (with DBG_BURST_EN) burst sequences.
module tb_mem_bus_dbg_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_bus_dbg_initiator_if bus();

  mem_bus_dbg_initiator dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0]  rxData    = '0;
  logic        rxValid   = 1'b0;
  logic        txReady   = 1'b1;
  logic        gnt       = 1'b0;
  logic        rdPattern = 1'b0;
  logic [15:0] rdConst   = '0;

  assign bus.rxData    = rxData;
  assign bus.rxValid   = rxValid;
  assign bus.txReady   = txReady;
  assign bus.busGnt    = gnt;
  assign bus.memDataIn = rdPattern ? {2'b01, bus.memAddr} : rdConst;

  int total = 0;
  int bad   = 0;

  int          gntDelay   = 0;
  int          reqCnt     = 0;
  int          reqHighCnt = 0;
  int          wrCount    = 0;
  logic [13:0] lastWrAddr = '0;
  logic [15:0] lastWrData = '0;

  // Core model: grant after gntDelay+1 requesting cycles; bus monitor for writes.
  always @(negedge clk) begin
    if (bus.busReq) begin
      reqCnt++;
      reqHighCnt++;
    end else begin
      reqCnt = 0;
    end
    gnt = bus.busReq && (reqCnt > gntDelay);
    if (bus.memWrEn) begin
      wrCount++;
      lastWrAddr = bus.memAddr;
      lastWrData = bus.memDataOut;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    rxData  = b;
    rxValid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.rxReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("rxReady.%02h", b), bus.rxReady, 1);
    @(posedge clk);
    #1;
    rxValid = 1'b0;
  endtask

  task automatic getByte(input logic [7:0] exp, input string name, output int lat);
    int n;
    n = 1;
    @(negedge clk);
    while (!bus.txValid && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    chk($sformatf("%s.txValid", name), bus.txValid, 1);
    chk($sformatf("%s.txData", name), bus.txData, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s.busy", name), bus.busy, 0);
    chk($sformatf("%s.rxReady", name), bus.rxReady, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    chk($sformatf("%s.rxReady", tag),    bus.rxReady,    1);
    chk($sformatf("%s.txValid", tag),    bus.txValid,    0);
    chk($sformatf("%s.txData", tag),     bus.txData,     0);
    chk($sformatf("%s.busReq", tag),     bus.busReq,     0);
    chk($sformatf("%s.memAddr", tag),    bus.memAddr,    0);
    chk($sformatf("%s.memDataOut", tag), bus.memDataOut, 0);
    chk($sformatf("%s.memWrEn", tag),    bus.memWrEn,    0);
    chk($sformatf("%s.busy", tag),       bus.busy,       0);
  endtask

  task automatic sendHeader(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] len);
    sendByte(h0);
    sendByte(h1);
`ifdef DBG_BURST_EN
    sendByte(len);
`endif
  endtask

  typedef struct {
    logic [7:0]  hdr0;
    logic [7:0]  hdr1;
    logic [15:0] wdata;
    logic [15:0] rdConst;
    logic [15:0] expWord;
    logic [13:0] expAddr;
    int          gntDelay;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] burstExp[6];

    vecs[0] = '{8'h80, 8'h0D, 16'hBEEF, 16'h0000, 16'hBEEF, 14'h000D, 0};
    vecs[1] = '{8'h00, 8'h04, 16'h0000, 16'h1234, 16'h1234, 14'h0004, 5};
    vecs[2] = '{8'hC1, 8'h23, 16'h5AA5, 16'h0000, 16'h5AA5, 14'h0123, 2};
    vecs[3] = '{8'h3F, 8'hFF, 16'h0000, 16'h8001, 16'h8001, 14'h3FFF, 0};
    vecs[4] = '{8'hBF, 8'hFF, 16'hFFFF, 16'h0000, 16'hFFFF, 14'h3FFF, 1};
    vecs[5] = '{8'h40, 8'hAB, 16'h0000, 16'h00FF, 16'h00FF, 14'h00AB, 3};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkReset("reset");
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      gntDelay   = vecs[i].gntDelay;
      rdPattern  = 1'b0;
      rdConst    = vecs[i].rdConst;
      wrCount    = 0;
      reqHighCnt = 0;
      sendHeader(vecs[i].hdr0, vecs[i].hdr1, 8'h01);
      if (vecs[i].hdr0[7]) begin
        sendByte(vecs[i].wdata[15:8]);
        sendByte(vecs[i].wdata[7:0]);
        waitIdle($sformatf("v%0d", i));
        chk($sformatf("v%0d.wrCount", i), wrCount, 1);
        chk($sformatf("v%0d.wrAddr", i), lastWrAddr, vecs[i].expAddr);
        chk($sformatf("v%0d.wrData", i), lastWrData, vecs[i].expWord);
      end else begin
        getByte(vecs[i].expWord[15:8], $sformatf("v%0d.hi", i), lat);
        chk($sformatf("v%0d.latency", i), lat, vecs[i].gntDelay + 3);
        getByte(vecs[i].expWord[7:0], $sformatf("v%0d.lo", i), lat);
        waitIdle($sformatf("v%0d", i));
        chk($sformatf("v%0d.wrCount", i), wrCount, 0);
      end
      chk($sformatf("v%0d.reqCycles", i), reqHighCnt, vecs[i].gntDelay + 2);
    end

    // Response backpressure: byte and valid held, link input held off.
    gntDelay = 0;
    rdConst  = 16'h1234;
    txReady  = 1'b0;
    sendHeader(8'h00, 8'h04, 8'h01);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.txValid && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.txValid", k), bus.txValid, 1);
      chk($sformatf("bp%0d.txData", k),  bus.txData,  8'h12);
      chk($sformatf("bp%0d.rxReady", k), bus.rxReady, 0);
    end
    @(posedge clk);
    #1;
    txReady = 1'b1;
    getByte(8'h12, "bp.hi", lat);
    getByte(8'h34, "bp.lo", lat);
    waitIdle("bp");

    // Reset landing in the ACC cycle of a write.
    gntDelay = 0;
    wrCount  = 0;
    sendHeader(8'h85, 8'h55, 8'h01);
    sendByte(8'hDE);
    sendByte(8'hAD);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstAcc.inAcc",   bus.busReq,  1);
    chk("rstAcc.memWrEn", bus.memWrEn, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkReset("rstAcc.after");
    chk("rstAcc.wrCount", wrCount, 0);
    @(posedge clk);
    #1;
    sendHeader(8'h80, 8'h07, 8'h01);
    sendByte(8'h12);
    sendByte(8'h34);
    waitIdle("postRst");
    chk("postRst.wrCount", wrCount, 1);
    chk("postRst.wrAddr",  lastWrAddr, 14'h0007);
    chk("postRst.wrData",  lastWrData, 16'h1234);

`ifdef DBG_BURST_EN
    // Burst read across the 14-bit address wrap; read data = {2'b01, addr}.
    burstExp   = '{8'h7F, 8'hFE, 8'h7F, 8'hFF, 8'h40, 8'h00};
    rdPattern  = 1'b1;
    gntDelay   = 0;
    wrCount    = 0;
    reqHighCnt = 0;
    sendHeader(8'h3F, 8'hFE, 8'h03);
    for (int b = 0; b < 6; b++) getByte(burstExp[b], $sformatf("burst%0d", b), lat);
    waitIdle("burst");
    chk("burst.wrCount",   wrCount, 0);
    chk("burst.reqCycles", reqHighCnt, 6);

    // Burst write: fresh data pair per access.
    rdPattern = 1'b0;
    wrCount   = 0;
    sendHeader(8'h80, 8'h10, 8'h02);
    sendByte(8'h11);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h22);
    waitIdle("burstWr");
    chk("burstWr.wrCount", wrCount, 2);
    chk("burstWr.wrAddr",  lastWrAddr, 14'h0011);
    chk("burstWr.wrData",  lastWrData, 16'h2222);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
